// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR configuration master.
// Register map, status bit positions, sequencer states and error codes.
package fir_pkg;

    localparam logic [11:0] ADDR_CTRL = 12'h000;
    localparam logic [11:0] ADDR_LEN  = 12'h010;
    localparam logic [11:0] ADDR_TAP0 = 12'h020;

    localparam int AP_START = 0;
    localparam int AP_DONE  = 1;
    localparam int AP_IDLE  = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_LEN,
        ST_WR_COEF,
        ST_RD_COEF,
        ST_WR_START,
        ST_POLL_RD,
        ST_POLL_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/axil_master_beat.sv
// Single-beat AXI-Lite master engine; aw and w handshakes tracked separately.
// ack pulses for one cycle after the beat completes; no new beat starts during it.
module axil_master_beat #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          rw,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          m_awvalid,
    output logic [AW-1:0] m_awaddr,
    input  logic          m_awready,
    output logic          m_wvalid,
    output logic [DW-1:0] m_wdata,
    input  logic          m_wready,
    output logic          m_arvalid,
    output logic [AW-1:0] m_araddr,
    input  logic          m_arready,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [DW-1:0] m_rdata
);

    logic          active_q, active_d;
    logic          awv_q, awv_d;
    logic          wv_q, wv_d;
    logic          arv_q, arv_d;
    logic          rr_q, rr_d;
    logic          awd_q, awd_d;
    logic          wd_q, wd_d;
    logic          ack_q, ack_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [DW-1:0] rdat_q, rdat_d;

    logic aw_hs, w_hs, ar_hs, r_hs;
    assign aw_hs = awv_q & m_awready;
    assign w_hs  = wv_q & m_wready;
    assign ar_hs = arv_q & m_arready;
    assign r_hs  = rr_q & m_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            awv_q    <= 1'b0;
            wv_q     <= 1'b0;
            arv_q    <= 1'b0;
            rr_q     <= 1'b0;
            awd_q    <= 1'b0;
            wd_q     <= 1'b0;
            ack_q    <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
        end else begin
            active_q <= active_d;
            awv_q    <= awv_d;
            wv_q     <= wv_d;
            arv_q    <= arv_d;
            rr_q     <= rr_d;
            awd_q    <= awd_d;
            wd_q     <= wd_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
        end
    end

    always_comb begin
        active_d = active_q;
        awv_d    = awv_q;
        wv_d     = wv_q;
        arv_d    = arv_q;
        rr_d     = rr_q;
        awd_d    = awd_q;
        wd_d     = wd_q;
        ack_d    = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        if (!active_q) begin
            if (req && !ack_q) begin
                active_d = 1'b1;
                addr_d   = addr;
                wdat_d   = wdata;
                awv_d    = rw;
                wv_d     = rw;
                arv_d    = !rw;
                rr_d     = !rw;
                awd_d    = 1'b0;
                wd_d     = 1'b0;
            end
        end else begin
            if (aw_hs) begin
                awv_d = 1'b0;
                awd_d = 1'b1;
            end
            if (w_hs) begin
                wv_d = 1'b0;
                wd_d = 1'b1;
            end
            if (ar_hs) begin
                arv_d = 1'b0;
            end
            if (r_hs) begin
                rr_d   = 1'b0;
                rdat_d = m_rdata;
            end
            // A write needs both channels; either may have finished earlier.
            if (((awd_q | aw_hs) & (wd_q | w_hs)) | r_hs) begin
                active_d = 1'b0;
                ack_d    = 1'b1;
            end
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdat_q;
    assign m_awvalid = awv_q;
    assign m_awaddr  = addr_q;
    assign m_wvalid  = wv_q;
    assign m_wdata   = wdat_q;
    assign m_arvalid = arv_q;
    assign m_araddr  = addr_q;
    assign m_rready  = rr_q;

endmodule

// File: rtl/fir_cfg_master.sv
// Hardware sequencer that programs, verifies and starts the FIR over AXI-Lite.
// Writes length and taps, reads taps back, writes ap_start, polls for done+idle.
module fir_cfg_master
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int POLL_GAP    = 4,
    parameter int POLL_MAX    = 65535
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst_n,
    input  logic                            cmd_start,
    input  logic [31:0]                     cmd_len,
    input  logic [Tape_Num*pDATA_WIDTH-1:0] cmd_coef,
    output logic                            awvalid,
    output logic [pADDR_WIDTH-1:0]          awaddr,
    input  logic                            awready,
    output logic                            wvalid,
    output logic [pDATA_WIDTH-1:0]          wdata,
    input  logic                            wready,
    output logic                            arvalid,
    output logic [pADDR_WIDTH-1:0]          araddr,
    input  logic                            arready,
    input  logic                            rvalid,
    output logic                            rready,
    input  logic [pDATA_WIDTH-1:0]          rdata,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      err,
    output logic [3:0]                      err_idx
);

    localparam int GW = $clog2(POLL_GAP + 1);

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [15:0]            poll_q, poll_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [31:0]            len_q, len_d;
    logic [pDATA_WIDTH-1:0] coef_q [Tape_Num];
    logic [pDATA_WIDTH-1:0] coef_d [Tape_Num];
    logic                   done_q, done_d;
    logic [1:0]             err_q, err_d;
    logic [3:0]             err_idx_q, err_idx_d;

    logic                   req, rw, ack;
    logic [pADDR_WIDTH-1:0] b_addr;
    logic [pDATA_WIDTH-1:0] b_wdata, b_rdata;
    logic                   last_tap;

    assign last_tap = (idx_q == 4'(Tape_Num - 1));

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= ERR_NONE;
            err_idx_q <= '0;
            for (int k = 0; k < Tape_Num; k++) coef_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            for (int k = 0; k < Tape_Num; k++) coef_q[k] <= coef_d[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        len_d     = len_q;
        coef_d    = coef_q;
        done_d    = done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (cmd_start) begin
                    state_d   = ST_WR_LEN;
                    len_d     = cmd_len;
                    for (int k = 0; k < Tape_Num; k++)
                        coef_d[k] = cmd_coef[k*pDATA_WIDTH +: pDATA_WIDTH];
                    done_d    = 1'b0;
                    err_d     = ERR_NONE;
                    err_idx_d = '0;
                end
            end
            ST_WR_LEN: begin
                if (ack) begin
                    state_d = ST_WR_COEF;
                    idx_d   = '0;
                end
            end
            ST_WR_COEF: begin
                if (ack) begin
                    if (last_tap) begin
                        state_d = ST_RD_COEF;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_RD_COEF: begin
                if (ack) begin
                    if (b_rdata != coef_q[idx_q]) begin
                        state_d   = ST_ERR;
                        err_d     = ERR_MISMATCH;
                        err_idx_d = idx_q;
                    end else if (last_tap) begin
                        state_d = ST_WR_START;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_WR_START: begin
                if (ack) begin
                    state_d = ST_POLL_RD;
                    poll_d  = '0;
                end
            end
            ST_POLL_RD: begin
                if (ack) begin
                    if (b_rdata[AP_DONE] && b_rdata[AP_IDLE]) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (poll_q == 16'(POLL_MAX - 1)) begin
                        state_d = ST_ERR;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        gap_d   = '0;
                        state_d = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) state_d = ST_POLL_RD;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b1;
        req     = 1'b1;
        rw      = 1'b0;
        b_addr  = pADDR_WIDTH'(ADDR_CTRL);
        b_wdata = '0;
        unique case (state_q)
            ST_WR_LEN: begin
                rw      = 1'b1;
                b_addr  = pADDR_WIDTH'(ADDR_LEN);
                b_wdata = pDATA_WIDTH'(len_q);
            end
            ST_WR_COEF: begin
                rw      = 1'b1;
                b_addr  = pADDR_WIDTH'(ADDR_TAP0) + pADDR_WIDTH'({idx_q, 2'b00});
                b_wdata = coef_q[idx_q];
            end
            ST_RD_COEF: begin
                b_addr = pADDR_WIDTH'(ADDR_TAP0) + pADDR_WIDTH'({idx_q, 2'b00});
            end
            ST_WR_START: begin
                rw      = 1'b1;
                b_wdata = pDATA_WIDTH'(1) << AP_START;
            end
            ST_POLL_RD: begin
            end
            ST_POLL_GAP: req = 1'b0;
            default: begin
                busy = 1'b0;
                req  = 1'b0;
            end
        endcase
    end

    axil_master_beat #(
        .AW (pADDR_WIDTH),
        .DW (pDATA_WIDTH)
    ) u_beat (
        .clk       (axis_clk),
        .rst_n     (axis_rst_n),
        .req       (req),
        .rw        (rw),
        .addr      (b_addr),
        .wdata     (b_wdata),
        .ack       (ack),
        .rdata     (b_rdata),
        .m_awvalid (awvalid),
        .m_awaddr  (awaddr),
        .m_awready (awready),
        .m_wvalid  (wvalid),
        .m_wdata   (wdata),
        .m_wready  (wready),
        .m_arvalid (arvalid),
        .m_araddr  (araddr),
        .m_arready (arready),
        .m_rvalid  (rvalid),
        .m_rready  (rready),
        .m_rdata   (rdata)
    );

    assign done    = done_q;
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master with a reactive AXI-Lite slave model.
// Expected transactions are queued at command time and popped as the slave sees them.
module tb_fir_cfg_master;
    import fir_pkg::*;

    localparam int NT = 11;
    localparam int PM = 8;

    logic           axis_clk = 1'b0;
    logic           axis_rst_n = 1'b0;
    logic           cmd_start;
    logic [31:0]    cmd_len;
    logic [NT*32-1:0] cmd_coef;
    logic           awvalid, wvalid, arvalid, rready;
    logic [11:0]    awaddr, araddr;
    logic [31:0]    wdata;
    logic           awready, wready, arready, rvalid;
    logic [31:0]    rdata;
    logic           busy, done;
    logic [1:0]     err;
    logic [3:0]     err_idx;

    always #5 axis_clk = ~axis_clk;

    fir_cfg_master #(.POLL_MAX(PM)) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_coef(cmd_coef),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [11:0] aw_log[$];
    logic [31:0] w_log[$];
    int          checks = 0;
    int          failures = 0;

    int          aw_dly = 0, w_dly = 0;
    bit          alt_en = 0, alt = 0, r_same = 0, corrupt = 0;
    int          poll_zero = 3;
    int          ctrl_rd = 0, ctrl_wr = 0;
    logic [31:0] mem [NT];

    int tn [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int t2 [NT] = '{5, 4, 3, 2, 1, 0, -1, -2, -3, -4, 100};
    int tx [NT] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_exp(input logic rw, input logic [11:0] a, input logic [31:0] d);
        txn_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_txn observed=%0h/%0h expected=none", rw, a);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("txn_rw", rw, e.rw);
            chk("txn_addr", a, e.addr);
            if (rw) chk("txn_wdata", d, e.data);
        end
    endtask

    task automatic push_seq(input logic [31:0] len, input int t [NT],
                            input int bad, input int npolls);
        exp_q.push_back({1'b1, ADDR_LEN, len});
        for (int k = 0; k < NT; k++)
            exp_q.push_back({1'b1, 12'(ADDR_TAP0 + 4*k), 32'(t[k])});
        for (int k = 0; k < NT; k++) begin
            exp_q.push_back({1'b0, 12'(ADDR_TAP0 + 4*k), 32'd0});
            if (k == bad) return;
        end
        exp_q.push_back({1'b1, ADDR_CTRL, 32'd1});
        for (int k = 0; k < npolls; k++) exp_q.push_back({1'b0, ADDR_CTRL, 32'd0});
    endtask

    task automatic start_cmd(input logic [31:0] len, input int t [NT]);
        cmd_len = len;
        for (int k = 0; k < NT; k++) cmd_coef[k*32 +: 32] = 32'(t[k]);
        cmd_start = 1'b1;
        @(negedge axis_clk);
        cmd_start = 1'b0;
        chk("busy_rise", busy, 1'b1);
        chk("done_clear", done, 1'b0);
        chk("err_clear", 32'(err), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge axis_clk);
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    // Reactive slave: drives on negedge, handshakes complete on the following posedge.
    initial begin : slave
        int   aw_cnt, w_cnt, ad, wd, ti;
        bit   aw_hs_p, w_hs_p, ar_hs_p, r_hs_p, rd_busy;
        logic [11:0] a;
        logic [31:0] d;
        awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
        aw_cnt = 0; w_cnt = 0; aw_hs_p = 0; w_hs_p = 0;
        ar_hs_p = 0; r_hs_p = 0; rd_busy = 0;
        for (int k = 0; k < NT; k++) mem[k] = 0;
        forever begin
            @(negedge axis_clk);
            if (!axis_rst_n) begin
                awready = 0; wready = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; aw_hs_p = 0; w_hs_p = 0;
                ar_hs_p = 0; r_hs_p = 0; rd_busy = 0;
                aw_log.delete(); w_log.delete();
            end else begin
                if (arvalid && (awvalid || wvalid)) chk("rw_overlap", {awvalid, wvalid}, 2'b00);
                ad = alt_en ? (alt ? 0 : 3) : aw_dly;
                wd = alt_en ? (alt ? 3 : 0) : w_dly;
                if (aw_hs_p) begin chk("aw_drop", awvalid, 1'b0); awready = 0; end
                if (w_hs_p) begin chk("w_drop", wvalid, 1'b0); wready = 0; end
                if (awvalid && !awready && !aw_hs_p) begin
                    if (aw_cnt >= ad) begin awready = 1; aw_log.push_back(awaddr); end
                    else aw_cnt++;
                end
                if (!awvalid) aw_cnt = 0;
                if (wvalid && !wready && !w_hs_p) begin
                    if (w_cnt >= wd) begin wready = 1; w_log.push_back(wdata); end
                    else w_cnt++;
                end
                if (!wvalid) w_cnt = 0;
                aw_hs_p = awvalid && awready;
                w_hs_p  = wvalid && wready;
                while (aw_log.size() > 0 && w_log.size() > 0) begin
                    a = aw_log.pop_front();
                    d = w_log.pop_front();
                    pop_exp(1'b1, a, d);
                    if (a == ADDR_CTRL) ctrl_wr++;
                    if (a >= ADDR_TAP0 && a < 12'(ADDR_TAP0 + 4*NT)) mem[(a - ADDR_TAP0) >> 2] = d;
                    if (alt_en) alt = !alt;
                end
                if (r_hs_p) begin rvalid = 0; rd_busy = 0; end
                if (ar_hs_p) begin
                    arready = 0;
                    if (rd_busy && !rvalid) rvalid = 1;
                end
                if (arvalid && !arready && !rd_busy) begin
                    arready = 1;
                    rd_busy = 1;
                    pop_exp(1'b0, araddr, 32'd0);
                    if (araddr == ADDR_CTRL) begin
                        rdata = (poll_zero < 0 || ctrl_rd < poll_zero) ? 32'h0 : 32'h6;
                        ctrl_rd++;
                    end else begin
                        ti = int'((araddr - ADDR_TAP0) >> 2);
                        rdata = (corrupt && ti == 3) ? 32'd24 : mem[ti];
                    end
                    rvalid = r_same;
                end
                ar_hs_p = arvalid && arready;
                r_hs_p  = rvalid && rready;
            end
        end
    end

    initial begin : stim
        int n;
        cmd_start = 0; cmd_len = 0; cmd_coef = '0;
        repeat (3) @(negedge axis_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        chk("rst_valids", {awvalid, wvalid, arvalid, rready}, 4'b0000);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        chk("rst_araddr", 32'(araddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        axis_rst_n = 1'b1;
        repeat (2) @(negedge axis_clk);

        // nominal
        poll_zero = 3; ctrl_rd = 0; ctrl_wr = 0;
        push_seq(32'd600, tn, -1, 4);
        start_cmd(32'd600, tn);
        wait_idle();
        chk("nom_done", done, 1'b1);
        chk("nom_err", 32'(err), 32'd0);
        chk("nom_polls", ctrl_rd, 4);
        chk("nom_ctrl_wr", ctrl_wr, 1);
        chk("nom_q_empty", exp_q.size(), 0);

        // restart from DONE with split channel timing, ignored mid-run start
        alt_en = 1; alt = 0; r_same = 1; poll_zero = 0; ctrl_rd = 0; ctrl_wr = 0;
        push_seq(32'd77, t2, -1, 1);
        start_cmd(32'd77, t2);
        n = 0;
        while (dut.state_q != ST_WR_COEF && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        chk("reach_wr_coef", 32'(dut.state_q), 32'(ST_WR_COEF));
        repeat (3) @(negedge axis_clk);
        cmd_len = 32'd999;
        for (int k = 0; k < NT; k++) cmd_coef[k*32 +: 32] = 32'(tx[k]);
        cmd_start = 1'b1;
        @(negedge axis_clk);
        cmd_start = 1'b0;
        chk("busy_mid", busy, 1'b1);
        wait_idle();
        chk("re_done", done, 1'b1);
        chk("re_err", 32'(err), 32'd0);
        chk("re_polls", ctrl_rd, 1);
        chk("re_q_empty", exp_q.size(), 0);

        // readback corruption on tap 3
        alt_en = 0; r_same = 0; corrupt = 1; ctrl_rd = 0; ctrl_wr = 0;
        push_seq(32'd600, tn, 3, 0);
        start_cmd(32'd600, tn);
        wait_idle();
        chk("cor_err", 32'(err), 32'(ERR_MISMATCH));
        chk("cor_err_idx", 32'(err_idx), 32'd3);
        chk("cor_done", done, 1'b0);
        chk("cor_no_start", ctrl_wr, 0);
        chk("cor_q_empty", exp_q.size(), 0);

        // poll timeout
        corrupt = 0; poll_zero = -1; ctrl_rd = 0; ctrl_wr = 0;
        push_seq(32'd5, tn, -1, PM);
        start_cmd(32'd5, tn);
        wait_idle();
        chk("to_err", 32'(err), 32'(ERR_TIMEOUT));
        chk("to_polls", ctrl_rd, PM);
        chk("to_done", done, 1'b0);
        chk("to_q_empty", exp_q.size(), 0);

        // reset while a write beat is stalled
        aw_dly = 1000; w_dly = 1000;
        exp_q.push_back({1'b1, ADDR_LEN, 32'd9});
        start_cmd(32'd9, tn);
        n = 0;
        while (!awvalid && n < 50) begin
            @(negedge axis_clk);
            n++;
        end
        chk("rst_pre_aw", awvalid, 1'b1);
        axis_rst_n = 1'b0;
        #1;
        chk("rstw_valids", {awvalid, wvalid}, 2'b00);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rstw_awaddr", 32'(awaddr), 32'd0);
        repeat (2) @(negedge axis_clk);
        exp_q.delete();
        axis_rst_n = 1'b1;
        repeat (5) @(negedge axis_clk);
        chk("post_rst_idle", {awvalid, wvalid, arvalid, busy}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
